seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 25 ++
 rtl/seq_gen.sv | 113 +++++++++++
 tb/tb_seq_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared FSM state encodings and symbol constants for the 1-2-3 burst generator.
// The GAP state exists only when SEQ_GEN_GAP_EN is defined.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
`ifdef SEQ_GEN_GAP_EN
    FIN  = 3'd4,
    GAP  = 3'd5
`else
    FIN  = 3'd4
`endif
  } state_e;

  localparam int unsigned REPS_W = 4;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_ONE   = 2'b01;
  localparam logic [1:0] SYM_TWO   = 2'b10;
  localparam logic [1:0] SYM_THREE = 2'b11;

endpackage

// File: rtl/seq_gen.sv
// Burst generator emitting reps triplets of symbols 01,10,11 with registered outputs.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between consecutive triplets.
module seq_gen
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [REPS_W-1:0] reps,
  output logic [1:0]        number,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [REPS_W-1:0] sent
);

  state_e            state_q;
  logic [REPS_W-1:0] reps_q;
  logic [REPS_W-1:0] sent_q;
  logic [1:0]        number_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [REPS_W-1:0] sent_d;

  // sent_q < reps_q whenever E3 is active, so this never wraps
  assign sent_d = sent_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      reps_q   <= '0;
      sent_q   <= '0;
      number_q <= SYM_IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // outputs are registered for the state being entered
      number_q <= SYM_IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            reps_q <= reps;
            sent_q <= '0;
            if (reps != '0) begin
              state_q  <= E1;
              number_q <= SYM_ONE;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        E1: begin
          state_q  <= E2;
          number_q <= SYM_TWO;
          valid_q  <= 1'b1;
          busy_q   <= 1'b1;
        end
        E2: begin
          state_q  <= E3;
          number_q <= SYM_THREE;
          valid_q  <= 1'b1;
          busy_q   <= 1'b1;
        end
        E3: begin
          sent_q <= sent_d;
          if (sent_d < reps_q) begin
`ifdef SEQ_GEN_GAP_EN
            state_q <= GAP;
            busy_q  <= 1'b1;
`else
            state_q  <= E1;
            number_q <= SYM_ONE;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
`endif
          end else begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          state_q  <= E1;
          number_q <= SYM_ONE;
          valid_q  <= 1'b1;
          busy_q   <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign number = number_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sent   = sent_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed and randomized bursts against a trace model.
module tb_seq_gen;

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] num;
    logic       v;
    logic       b;
    logic       d;
    logic [3:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] reps;
  logic [1:0] number;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] sent;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_sent = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  seq_gen dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .reps   (reps),
    .number (number),
    .valid  (valid),
    .busy   (busy),
    .done   (done),
    .sent   (sent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t idle_exp(input int s);
    return '{num: 2'b00, v: 1'b0, b: 1'b0, d: 1'b0, s: 4'(s)};
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check(tag, 32'({number, valid, busy, done, sent}), 32'(e));
  endtask

  // Expected per-cycle trace of a burst, starting the cycle after start is accepted
  function automatic void build(input int n);
    q.delete();
    for (int t = 0; t < n; t++) begin
      for (int k = 1; k <= 3; k++)
        q.push_back('{num: 2'(k), v: 1'b1, b: 1'b1, d: 1'b0, s: 4'(t)});
      if (GAP_ON && t < n - 1)
        q.push_back('{num: 2'b00, v: 1'b0, b: 1'b1, d: 1'b0, s: 4'(t + 1)});
    end
    q.push_back('{num: 2'b00, v: 1'b0, b: 1'b0, d: 1'b1, s: 4'(n)});
  endfunction

  // noise: 0 = quiet inputs, 1 = random start/reps, 2 = start with reps=5
  task automatic run_burst(input int n, input int noise, input int rst_at);
    int ans;
    logic [1:0] h1, h2;
    ans = 0;
    h1 = 2'b00;
    h2 = 2'b00;
    build(n);
    start = 1'b1;
    reps  = 4'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      check_out($sformatf("r%0d_c%0d", n, i), q[i]);
      if (valid) begin
        if (h2 == 2'b01 && h1 == 2'b10 && number == 2'b11) ans++;
        h2 = h1;
        h1 = number;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        start = 1'b1;
        reps  = 4'd7;
        step();
        reset = 1'b0;
        start = 1'b0;
        check_out($sformatf("r%0d_rst", n), idle_exp(0));
        step();
        check_out($sformatf("r%0d_rst_after", n), idle_exp(0));
        last_sent = 0;
        return;
      end
      if (noise == 1) begin
        start = 1'($urandom);
        reps  = 4'($urandom);
      end else if (noise == 2) begin
        start = 1'b1;
        reps  = 4'd5;
      end
      step();
    end
    start = 1'b0;
    check_out($sformatf("r%0d_idle", n), idle_exp(n));
    check($sformatf("r%0d_ans", n), 32'(ans), 32'(n));
    last_sent = n;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    reps  = 4'd5;
    step();
    step();
    check_out("reset_state", idle_exp(0));
    reset = 1'b0;
    start = 1'b0;
    step();
    check_out("post_reset_idle", idle_exp(0));

    run_burst(1, 0, -1);
    run_burst(3, 0, -1);
    run_burst(2, 0, -1);
    run_burst(0, 0, -1);
    run_burst(1, 2, -1);
    run_burst(15, 1, -1);
    run_burst(4, 0, GAP_ON ? 6 : 5);

    for (int b = 0; b < 14; b++) begin
      int gap;
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), -1);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        check_out($sformatf("idle_gap%0d_%0d", b, g), idle_exp(last_sent));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
